// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB write-side controller.
package btb_pkg;

    localparam int unsigned BTB_SIZE  = 128;
    localparam int unsigned BTB_WIDTH = 32;
    localparam int unsigned IDX_W     = $clog2(BTB_SIZE);
    localparam int unsigned TAG_W     = BTB_WIDTH - 2 - IDX_W;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [IDX_W-1:0]     index;
        logic [TAG_W-1:0]     tag;
        logic [BTB_WIDTH-1:0] target;
        logic                 taken;
    } btb_upd_t;

    typedef enum logic {S_SWEEP, S_RUN} state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of pending BTB updates with a synchronous clear.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  btb_upd_t                 din_i,
    output btb_upd_t                 head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    btb_upd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Resolves CTIs against their prediction, raises flush/redirect, and arbitrates
// queued BTB updates against the invalidate sweep on the single write port.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned SIZE       = BTB_SIZE,
    parameter int unsigned WIDTH      = BTB_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic              ex_is_cti_i,
    input  logic [WIDTH-1:0]  ex_pc_i,
    input  logic [WIDTH-1:0]  ex_target_i,
    input  logic              ex_taken_i,
    input  logic              ex_pred_taken_i,
    input  logic [WIDTH-1:0]  ex_pred_pc_i,
    input  logic              invalidate_req_i,
    input  logic              btb_ready_i,
    output logic              btb_wr_en_o,
    output logic              btb_wr_inval_o,
    output logic [IDX_W-1:0]  btb_wr_index_o,
    output logic [TAG_W-1:0]  btb_wr_tag_o,
    output logic [WIDTH-1:0]  btb_wr_target_o,
    output logic              btb_wr_taken_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic [WIDTH-1:0]  redirect_pc_o,
    output logic              busy_o,
    output logic [31:0]       cnt_cti_o,
    output logic [31:0]       cnt_mispred_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state, state_n;
    logic [IDX_W-1:0]   sweep_idx, sweep_idx_n;
    logic               accept, mispred;
    logic               fifo_push, fifo_pop, fifo_clr;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    btb_upd_t           fifo_din, fifo_head;

    assign stall_o = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign accept  = ex_valid_i & ex_is_cti_i & ~stall_o;
    assign mispred = (ex_taken_i != ex_pred_taken_i) |
                     (ex_taken_i & ex_pred_taken_i & (ex_target_i != ex_pred_pc_i));
    assign busy_o  = (state == S_SWEEP);

    assign fifo_din.index  = ex_pc_i[IDX_W+1:2];
    assign fifo_din.tag    = ex_pc_i[WIDTH-1:IDX_W+2];
    assign fifo_din.target = ex_target_i;
    assign fifo_din.taken  = ex_taken_i;

    assign fifo_push = accept & (state == S_RUN) & ~fifo_full;
    assign fifo_pop  = (state == S_RUN) & ~fifo_empty & btb_ready_i;

    btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (fifo_din),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_SWEEP;
            sweep_idx <= '0;
        end else begin
            state     <= state_n;
            sweep_idx <= sweep_idx_n;
        end
    end

    always_comb begin
        state_n         = state;
        sweep_idx_n     = sweep_idx;
        fifo_clr        = 1'b0;
        btb_wr_en_o     = 1'b0;
        btb_wr_inval_o  = 1'b0;
        btb_wr_index_o  = '0;
        btb_wr_tag_o    = '0;
        btb_wr_target_o = '0;
        btb_wr_taken_o  = 1'b0;
        case (state)
            S_SWEEP: begin
                btb_wr_en_o    = 1'b1;
                btb_wr_inval_o = 1'b1;
                btb_wr_index_o = sweep_idx;
                // A restart request outranks progress on the current index.
                if (invalidate_req_i) begin
                    sweep_idx_n = '0;
                end else if (btb_ready_i) begin
                    sweep_idx_n = sweep_idx + IDX_W'(1);
                    if (sweep_idx == IDX_W'(SIZE - 1)) state_n = S_RUN;
                end
            end
            S_RUN: begin
                btb_wr_en_o     = ~fifo_empty;
                btb_wr_index_o  = fifo_head.index;
                btb_wr_tag_o    = fifo_head.tag;
                btb_wr_target_o = fifo_head.target;
                btb_wr_taken_o  = fifo_head.taken;
                if (invalidate_req_i) begin
                    state_n     = S_SWEEP;
                    sweep_idx_n = '0;
                    fifo_clr    = 1'b1;
                end
            end
            default: state_n = S_SWEEP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_o       <= 1'b0;
            redirect_pc_o <= '0;
            cnt_cti_o     <= '0;
            cnt_mispred_o <= '0;
        end else begin
            flush_o <= accept & mispred;
            if (accept) begin
                cnt_cti_o <= cnt_cti_o + 32'd1;
                if (mispred) begin
                    cnt_mispred_o <= cnt_mispred_o + 32'd1;
                    redirect_pc_o <= ex_taken_i ? ex_target_i : ex_pc_i + WIDTH'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: sweep, resolve/flush vectors, stall and invalidate sequences.
module tb_btb_update_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_is_cti_i, ex_taken_i, ex_pred_taken_i;
    logic [31:0] ex_pc_i, ex_target_i, ex_pred_pc_i;
    logic        invalidate_req_i, btb_ready_i;
    logic        btb_wr_en_o, btb_wr_inval_o, btb_wr_taken_o;
    logic [6:0]  btb_wr_index_o;
    logic [22:0] btb_wr_tag_o;
    logic [31:0] btb_wr_target_o;
    logic        stall_o, flush_o, busy_o;
    logic [31:0] redirect_pc_o, cnt_cti_o, cnt_mispred_o;

    int checks = 0;
    int errors = 0;
    int exp_cti = 0;
    int exp_mis = 0;

    always #5 clk_i = ~clk_i;

    btb_update_ctrl #(.SIZE(128), .WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ex_valid_i       (ex_valid_i),
        .ex_is_cti_i      (ex_is_cti_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .ex_taken_i       (ex_taken_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_pc_i     (ex_pred_pc_i),
        .invalidate_req_i (invalidate_req_i),
        .btb_ready_i      (btb_ready_i),
        .btb_wr_en_o      (btb_wr_en_o),
        .btb_wr_inval_o   (btb_wr_inval_o),
        .btb_wr_index_o   (btb_wr_index_o),
        .btb_wr_tag_o     (btb_wr_tag_o),
        .btb_wr_target_o  (btb_wr_target_o),
        .btb_wr_taken_o   (btb_wr_taken_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o),
        .cnt_cti_o        (cnt_cti_o),
        .cnt_mispred_o    (cnt_mispred_o)
    );

    typedef struct {
        logic [31:0] pc, target, pred_pc;
        logic        taken, pred_taken;
        logic        e_flush;
        logic [31:0] e_redirect;
        logic [6:0]  e_index;
        logic [22:0] e_tag;
        logic [31:0] e_target;
        logic        e_taken;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                         input logic ptk, input logic [31:0] ppc);
        ex_valid_i      = 1'b1;
        ex_is_cti_i     = 1'b1;
        ex_pc_i         = pc;
        ex_target_i     = tgt;
        ex_taken_i      = tk;
        ex_pred_taken_i = ptk;
        ex_pred_pc_i    = ppc;
    endtask

    task automatic full_sweep(input string tag);
        for (int i = 0; i < 128; i++) begin
            chk({tag, "_busy"}, 32'(busy_o), 32'd1);
            chk({tag, "_inval"}, 32'({btb_wr_en_o, btb_wr_inval_o}), 32'd3);
            chk({tag, "_index"}, 32'(btb_wr_index_o), 32'(i));
            step();
        end
        chk({tag, "_done_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done_wr_en"}, 32'(btb_wr_en_o), 32'd0);
    endtask

    initial begin
        // pc, target, pred_pc, taken, pred_taken, flush, redirect, index, tag, target, taken
        vecs[0] = '{32'h100, 32'h80, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80, 7'h40, 23'h0, 32'h80, 1'b1};
        vecs[1] = '{32'h200, 32'h300, 32'h300, 1'b1, 1'b1, 1'b0, 32'h80, 7'h00, 23'h1, 32'h300, 1'b1};
        vecs[2] = '{32'h204, 32'h400, 32'h400, 1'b0, 1'b1, 1'b1, 32'h208, 7'h01, 23'h1, 32'h400, 1'b0};
        vecs[3] = '{32'h1000_0010, 32'h60, 32'h50, 1'b1, 1'b1, 1'b1, 32'h60, 7'h04, 23'h80000, 32'h60, 1'b1};
        vecs[4] = '{32'hFFFF_FFFC, 32'h10, 32'h10, 1'b0, 1'b1, 1'b1, 32'h0, 7'h7F, 23'h7FFFFF, 32'h10, 1'b0};
        vecs[5] = '{32'h300, 32'h999, 32'h123, 1'b0, 1'b0, 1'b0, 32'h0, 7'h40, 23'h1, 32'h999, 1'b0};

        rst_i = 1'b1; btb_ready_i = 1'b1; invalidate_req_i = 1'b0;
        ex_valid_i = 1'b0; ex_is_cti_i = 1'b0; ex_taken_i = 1'b0; ex_pred_taken_i = 1'b0;
        ex_pc_i = '0; ex_target_i = '0; ex_pred_pc_i = '0;
        step();
        step();
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_redirect", redirect_pc_o, 32'd0);
        chk("rst_cnt_cti", cnt_cti_o, 32'd0);
        chk("rst_cnt_mis", cnt_mispred_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        full_sweep("reset_sweep");

        // Table-driven resolve vectors, ready held high.
        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].pc, vecs[v].target, vecs[v].taken, vecs[v].pred_taken, vecs[v].pred_pc);
            step();
            ex_valid_i = 1'b0;
            exp_cti++;
            if (vecs[v].e_flush) exp_mis++;
            chk($sformatf("v%0d_flush", v), 32'(flush_o), 32'(vecs[v].e_flush));
            chk($sformatf("v%0d_redirect", v), redirect_pc_o, vecs[v].e_redirect);
            chk($sformatf("v%0d_wr_en", v), 32'({btb_wr_en_o, btb_wr_inval_o}), 32'd2);
            chk($sformatf("v%0d_index", v), 32'(btb_wr_index_o), 32'(vecs[v].e_index));
            chk($sformatf("v%0d_tag", v), 32'(btb_wr_tag_o), 32'(vecs[v].e_tag));
            chk($sformatf("v%0d_target", v), btb_wr_target_o, vecs[v].e_target);
            chk($sformatf("v%0d_taken", v), 32'(btb_wr_taken_o), 32'(vecs[v].e_taken));
            chk($sformatf("v%0d_cnt_cti", v), cnt_cti_o, 32'(exp_cti));
            chk($sformatf("v%0d_cnt_mis", v), cnt_mispred_o, 32'(exp_mis));
            step();
            chk($sformatf("v%0d_flush_pulse", v), 32'(flush_o), 32'd0);
            chk($sformatf("v%0d_drained", v), 32'(btb_wr_en_o), 32'd0);
        end

        // Non-CTI and invalid CTI are ignored.
        drive(32'h700, 32'h40, 1'b1, 1'b0, 32'h0);
        ex_is_cti_i = 1'b0;
        step();
        ex_is_cti_i = 1'b1; ex_valid_i = 1'b0;
        step();
        ex_is_cti_i = 1'b0;
        chk("noncti_flush", 32'(flush_o), 32'd0);
        chk("noncti_wr_en", 32'(btb_wr_en_o), 32'd0);
        chk("noncti_cnt", cnt_cti_o, 32'(exp_cti));

        // Back-to-back CTIs with the write port blocked.
        btb_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fill%0d_stall", k), 32'(stall_o), 32'd0);
            drive(32'h400 + 32'(4 * k), 32'h0, 1'b0, 1'b0, 32'h0);
            step();
        end
        exp_cti += 4;
        chk("full_stall", 32'(stall_o), 32'd1);
        drive(32'h410, 32'h700, 1'b1, 1'b0, 32'h0);
        step();
        step();
        chk("held_stall", 32'(stall_o), 32'd1);
        chk("held_flush", 32'(flush_o), 32'd0);
        chk("held_cnt", cnt_cti_o, 32'(exp_cti));
        chk("held_wr_index", 32'(btb_wr_index_o), 32'd0);
        chk("held_wr_en", 32'({btb_wr_en_o, btb_wr_inval_o}), 32'd2);
        btb_ready_i = 1'b1;
        step();
        chk("popA_stall", 32'(stall_o), 32'd0);
        chk("popA_flush", 32'(flush_o), 32'd0);
        chk("popA_index", 32'(btb_wr_index_o), 32'd1);
        chk("popA_cnt", cnt_cti_o, 32'(exp_cti));
        step();
        ex_valid_i = 1'b0;
        exp_cti++; exp_mis++;
        chk("popB_flush", 32'(flush_o), 32'd1);
        chk("popB_redirect", redirect_pc_o, 32'h700);
        chk("popB_cnt", cnt_cti_o, 32'(exp_cti));
        chk("popB_cnt_mis", cnt_mispred_o, 32'(exp_mis));
        chk("popB_index", 32'(btb_wr_index_o), 32'd2);
        step();
        chk("popC_flush", 32'(flush_o), 32'd0);
        chk("popC_index", 32'(btb_wr_index_o), 32'd3);
        chk("popC_cnt", cnt_cti_o, 32'(exp_cti));
        step();
        chk("popD_index", 32'(btb_wr_index_o), 32'd4);
        chk("popD_target", btb_wr_target_o, 32'h700);
        chk("popD_taken", 32'(btb_wr_taken_o), 32'd1);
        step();
        chk("popE_wr_en", 32'(btb_wr_en_o), 32'd0);
        chk("popE_cnt", cnt_cti_o, 32'(exp_cti));

        // Invalidate with queued entries, mispredict during sweep, restart mid-sweep.
        btb_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(32'h500 + 32'(4 * k), 32'h0, 1'b0, 1'b0, 32'h0);
            step();
        end
        ex_valid_i = 1'b0;
        exp_cti += 3;
        chk("q3_wr_index", 32'(btb_wr_index_o), 32'h40);
        invalidate_req_i = 1'b1;
        step();
        invalidate_req_i = 1'b0;
        chk("inv_busy", 32'(busy_o), 32'd1);
        chk("inv_wr", 32'({btb_wr_en_o, btb_wr_inval_o}), 32'd3);
        chk("inv_index", 32'(btb_wr_index_o), 32'd0);
        chk("inv_stall", 32'(stall_o), 32'd0);
        drive(32'h600, 32'h900, 1'b1, 1'b0, 32'h0);
        step();
        ex_valid_i = 1'b0;
        exp_cti++; exp_mis++;
        chk("swmis_flush", 32'(flush_o), 32'd1);
        chk("swmis_redirect", redirect_pc_o, 32'h900);
        chk("swmis_cnt", cnt_cti_o, 32'(exp_cti));
        chk("swmis_cnt_mis", cnt_mispred_o, 32'(exp_mis));
        chk("swmis_inval", 32'(btb_wr_inval_o), 32'd1);
        chk("swmis_index", 32'(btb_wr_index_o), 32'd0);
        btb_ready_i = 1'b1;
        step(); step(); step();
        chk("partial_index", 32'(btb_wr_index_o), 32'd3);
        invalidate_req_i = 1'b1;
        step();
        invalidate_req_i = 1'b0;
        full_sweep("restart_sweep");
        chk("final_cnt_cti", cnt_cti_o, 32'(exp_cti));
        chk("final_cnt_mis", cnt_mispred_o, 32'(exp_mis));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Controller that owns the write side of the branch target buffer. It resolves each control-transfer instruction (CTI) leaving EX against the prediction carried down the pipe, and issues a registered flush/redirect to fetch on a mispredict. Updates queue in a small FIFO and are arbitrated onto the single BTB write port against a sequential invalidate sweep, which runs after reset and on request. It also keeps CTI and mispredict counters.

Parameters:
SIZE, 128, BTB entries; power of 2. IDX_W = log2(SIZE) = 7.
WIDTH, 32, PC/target width; TAG_W = WIDTH-2-IDX_W = 23.
FIFO_DEPTH, 4, update queue entries; power of 2, ≥2.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
ex_valid_i  in  1  EX holds a valid instruction
ex_is_cti_i  in  1  EX opcode is BRANCH, JAL or JALR
ex_pc_i  in  WIDTH  PC of EX instruction
ex_target_i  in  WIDTH  resolved target (ALU output)
ex_taken_i  in  1  resolved taken
ex_pred_taken_i  in  1  fetch-time BTB prediction, piped to EX
ex_pred_pc_i  in  WIDTH  fetch-time predicted target
invalidate_req_i  in  1  pulse: clear whole BTB
btb_ready_i  in  1  BTB write port accepts this cycle
btb_wr_en_o  out  1  write request
btb_wr_inval_o  out  1  write clears entry (valid=0, counter=00)
btb_wr_index_o  out  IDX_W  entry index
btb_wr_tag_o  out  TAG_W  tag = pc[WIDTH-1:IDX_W+2]
btb_wr_target_o  out  WIDTH  target
btb_wr_taken_o  out  1  outcome, drives 2-bit counter update in BTB
stall_o  out  1  FIFO full; EX must hold
flush_o  out  1  mispredict pulse to IF/ID
redirect_pc_o  out  WIDTH  correct next PC, valid with flush_o
busy_o  out  1  sweep in progress
cnt_cti_o  out  32  accepted CTIs
cnt_mispred_o  out  32  mispredicts

Behaviour:
- Accept = ex_valid_i & ex_is_cti_i & !stall_o. Non-CTI or invalid: ignored.
- Mispredict = (ex_taken_i != ex_pred_taken_i) | (ex_taken_i & ex_pred_taken_i & ex_target_i != ex_pred_pc_i).
- flush_o/redirect_pc_o registered, 1-cycle latency after accepting a mispredict. redirect_pc_o = taken ? ex_target_i : ex_pc_i+4, mod 2^WIDTH. flush_o is a 1-cycle pulse. redirect_pc_o holds its last value otherwise.
- FIFO entry = {index, tag, target, taken}. Push on accept in RUN. Pop when btb_wr_en_o & !btb_wr_inval_o & btb_ready_i.
- stall_o = (count == FIFO_DEPTH), combinational from count only. A same-cycle pop does not clear stall. An event held under stall is accepted once stall drops, with exactly one push, one flush and one count.
- Push and pop in the same cycle: count unchanged.
- FSM states:
  - SWEEP: btb_wr_en_o=1, btb_wr_inval_o=1, btb_wr_index_o=sweep_idx. sweep_idx increments when btb_ready_i=1. Leave to RUN after the write at SIZE-1 is accepted. busy_o=1. The FIFO is cleared on entry. Accepted CTIs still generate flush and counts but are not pushed.
  - RUN: btb_wr_en_o = FIFO non-empty, driven from the head entry. An invalidate_req_i pulse moves to SWEEP with sweep_idx=0 and discards FIFO contents.
  - invalidate_req_i during SWEEP restarts sweep_idx at 0.
- Reset: state=SWEEP, sweep_idx=0, FIFO empty.
  - Outputs in the reset cycle: flush_o=0, redirect_pc_o=0, counters=0, stall_o=0.
  - busy_o=1 from the first cycle after reset.
  - Reset during a sweep restarts it at index 0.
- Write outputs are stable while btb_wr_en_o=1 and btb_ready_i=0.
- Counters: cnt_cti_o increments on accept; cnt_mispred_o increments on an accepted mispredict. Both wrap mod 2^32.

Decomposition:
- Package btb_pkg: SIZE/WIDTH defaults, IDX_W, TAG_W, opcode constants (BRANCH/JAL/JALR), btb_upd_t struct {index, tag, target, taken}, FSM enum {S_SWEEP, S_RUN}.
- One sub-module: btb_upd_fifo (parameterised sync FIFO of btb_upd_t with push/pop/count/full/empty, synchronous clear).

Test Plan:
- Reset with btb_ready_i=1 -> busy_o=1 for 128 cycles, inval writes to indices 0..127 in order, then btb_wr_en_o=0 and busy_o=0.
- RUN: BEQ at pc 0x100, pred not-taken, taken to 0x80 -> next cycle flush_o=1, redirect_pc_o=0x80. FIFO write: index 0x40, tag 0, target 0x80, taken=1. cnt_mispred_o=1.
- JAL at pc 0x200, pred taken, pred_pc=0x300=target -> no flush. cnt_cti_o increments, cnt_mispred_o unchanged, one write issued.
- BNE at 0x204, pred taken, actually not taken -> flush_o=1, redirect_pc_o=0x208.
- btb_ready_i=0, 5 back-to-back CTIs -> stall_o=1 after the 4th. Raise ready -> 4 writes in FIFO order, 5th accepted exactly once.
- FIFO holding 3 entries, invalidate_req_i pulse -> entries dropped, sweep restarts at index 0. A mispredict during the sweep still flushes but produces no write.
